// File: rtl/sar_adc_ctrl_mc.sv
// Multi-channel successive-approximation ADC controller with a round-robin channel
// scheduler, single-shot/continuous modes and abort-on-disable.
module sar_adc_ctrl_mc #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NCH           = 4,
  parameter int unsigned SAMPLE_CYCLES = 1,
  localparam int unsigned CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp,
  output logic             sample,
  output logic [CHW-1:0]   ch_sel,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] digital_out,
  output logic [CHW-1:0]   out_ch,
  output logic             out_flag,
  output logic             busy
);

  localparam int unsigned BW  = $clog2(WIDTH);
  localparam int unsigned SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSample, StConvert, StDone} state_e;

  state_e           state_q, state_d;
  logic [CHW-1:0]   ch_sel_q, ch_sel_d;
  logic [CHW-1:0]   ptr_q, ptr_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;
  logic             flag_q, flag_d;

  logic [CHW-1:0]   nxt_ch;
  logic             can_go;
  logic [WIDTH-1:0] trial;

  // First enabled channel strictly after ptr, wrapping; returns ptr if none enabled.
  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] ptr,
                                             input logic [NCH-1:0] mask);
    logic [CHW-1:0] pick;
    logic           found;
    logic [NCH-1:0] sh;
    int unsigned    idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      sh = mask >> idx;
      if (!found && sh[0]) begin
        pick  = CHW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign nxt_ch = next_ch(ptr_q, ch_mask);
  assign can_go = enable && (ch_mask != '0);

  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    ptr_d    = ptr_q;
    scnt_d   = scnt_q;
    bit_d    = bit_q;
    result_d = result_q;
    dout_d   = dout_q;
    out_ch_d = out_ch_q;
    flag_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (can_go && (mode || start)) begin
          state_d  = StSample;
          ch_sel_d = nxt_ch;
          ptr_d    = nxt_ch;
          scnt_d   = '0;
        end
      end
      StSample: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (scnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
          state_d  = StConvert;
          bit_d    = BW'(WIDTH - 1);
          result_d = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      StConvert: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          result_d[bit_q] = cmp;
          if (bit_q == '0) begin
            state_d = StDone;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      StDone: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          dout_d   = result_q;
          out_ch_d = ch_sel_q;
          flag_d   = 1'b1;
          // Continuous mode chains straight into the next sample with no idle bubble.
          if (mode && (ch_mask != '0)) begin
            state_d  = StSample;
            ch_sel_d = nxt_ch;
            ptr_d    = nxt_ch;
            scnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_sel_q <= '0;
      ptr_q    <= CHW'(NCH - 1);
      scnt_q   <= '0;
      bit_q    <= '0;
      result_q <= '0;
      dout_q   <= '0;
      out_ch_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_sel_q <= ch_sel_d;
      ptr_q    <= ptr_d;
      scnt_q   <= scnt_d;
      bit_q    <= bit_d;
      result_q <= result_d;
      dout_q   <= dout_d;
      out_ch_q <= out_ch_d;
      flag_q   <= flag_d;
    end
  end

  // Bits below the one under test are still zero, so OR-ing in the trial bit is exact.
  assign trial       = result_q | (WIDTH'(1) << bit_q);
  assign value       = (state_q == StConvert) ? trial : '0;
  assign sample      = (state_q == StSample);
  assign busy        = (state_q != StIdle);
  assign ch_sel      = ch_sel_q;
  assign digital_out = dout_q;
  assign out_ch      = out_ch_q;
  assign out_flag    = flag_q;

endmodule

// File: tb/tb_sar_adc_ctrl_mc.sv
// Randomized bench for sar_adc_ctrl_mc: two instances (8-bit/1-sample and 12-bit/3-sample)
// share control inputs; a transaction-level model predicts channels, timing and codes.
module tb_sar_adc_ctrl_mc;

  typedef struct {
    int dut;
    int cyc;
    int ch;
    int data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] ch_mask = 4'b0000;

  logic        cmp8, cmp12, smp8, smp12, flag8, flag12, busy8, busy12;
  logic [1:0]  chs8, chs12, och8, och12;
  logic [7:0]  val8, dout8;
  logic [11:0] val12, dout12;

  logic [7:0]  code8 [4];
  logic [11:0] code12 [4];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int lat [2] = '{10, 16};
  int scyc [2] = '{1, 3};
  int ptr [2] = '{3, 3};
  int last_data [2] = '{0, 0};
  int last_ch [2] = '{0, 0};
  int scnt [2] = '{0, 0};
  ev_t evq [$];
  int  vals8 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Analog front end: each channel holds a fixed code.
  assign cmp8  = (code8[chs8] >= val8);
  assign cmp12 = (code12[chs12] >= val12);

  sar_adc_ctrl_mc #(.WIDTH(8), .NCH(4), .SAMPLE_CYCLES(1)) u_dut8 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .mode(mode), .ch_mask(ch_mask),
    .cmp(cmp8), .sample(smp8), .ch_sel(chs8), .value(val8), .digital_out(dout8),
    .out_ch(och8), .out_flag(flag8), .busy(busy8)
  );

  sar_adc_ctrl_mc #(.WIDTH(12), .NCH(4), .SAMPLE_CYCLES(3)) u_dut12 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .mode(mode), .ch_mask(ch_mask),
    .cmp(cmp12), .sample(smp12), .ch_sel(chs12), .value(val12), .digital_out(dout12),
    .out_ch(och12), .out_flag(flag12), .busy(busy12)
  );

  task automatic log_ev(input int d, input int ch, input int data);
    ev_t e;
    e.dut  = d;
    e.cyc  = cyc;
    e.ch   = ch;
    e.data = data;
    evq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (flag8) log_ev(0, int'(och8), int'(dout8));
    if (flag12) log_ev(1, int'(och12), int'(dout12));
    if (val8 != 8'd0) vals8.push_back(int'(val8));
    if (smp8) scnt[0] = scnt[0] + 1;
    if (smp12) scnt[1] = scnt[1] + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    evq.delete();
    vals8.delete();
    scnt[0] = 0;
    scnt[1] = 0;
  endtask

  function automatic int rr_next(input int p, input logic [3:0] m);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (p + k) % 4;
      if (((m >> idx) & 4'd1) != 4'd0) return idx;
    end
    return p;
  endfunction

  function automatic int exp_code(input int d, input logic [1:0] ch);
    return (d == 0) ? int'(code8[ch]) : int'(code12[ch]);
  endfunction

  task automatic check_reset(input string tag);
    check_val({tag, "_sample8"}, 32'(smp8), 0);
    check_val({tag, "_value8"}, 32'(val8), 0);
    check_val({tag, "_chsel8"}, 32'(chs8), 0);
    check_val({tag, "_dout8"}, 32'(dout8), 0);
    check_val({tag, "_outch8"}, 32'(och8), 0);
    check_val({tag, "_flag8"}, 32'(flag8), 0);
    check_val({tag, "_busy8"}, 32'(busy8), 0);
    check_val({tag, "_sample12"}, 32'(smp12), 0);
    check_val({tag, "_value12"}, 32'(val12), 0);
    check_val({tag, "_dout12"}, 32'(dout12), 0);
    check_val({tag, "_busy12"}, 32'(busy12), 0);
  endtask

  // Compare logged results of one DUT against the round-robin/latency model.
  task automatic check_run(input int d, input int acc, input int n_done, input int extra,
                           input logic [3:0] m, input string tag);
    int j;
    int ch;
    int exp_d;
    j = 0;
    foreach (evq[k]) begin
      if (evq[k].dut == d) begin
        ch = rr_next(ptr[d], m);
        ptr[d] = ch;
        exp_d = exp_code(d, 2'(ch));
        check_val($sformatf("%s_d%0d_cyc%0d", tag, d, j), evq[k].cyc, acc + lat[d] * (j + 1));
        check_val($sformatf("%s_d%0d_ch%0d", tag, d, j), evq[k].ch, ch);
        check_val($sformatf("%s_d%0d_data%0d", tag, d, j), evq[k].data, exp_d);
        last_data[d] = exp_d;
        last_ch[d] = ch;
        j++;
      end
    end
    check_val($sformatf("%s_d%0d_count", tag, d), j, n_done);
    for (int i = j; i < n_done + extra; i++) ptr[d] = rr_next(ptr[d], m);
    check_val($sformatf("%s_d%0d_dout", tag, d), (d == 0) ? 32'(dout8) : 32'(dout12),
              last_data[d]);
    check_val($sformatf("%s_d%0d_outch", tag, d), (d == 0) ? 32'(och8) : 32'(och12),
              last_ch[d]);
  endtask

  task automatic do_single(input logic [3:0] m, input string tag);
    int acc;
    int r;
    int t;
    int k;
    int got;
    clear();
    ch_mask = m;
    enable = 1'b1;
    start = 1'b1;
    acc = cyc + 1;
    tick();
    start = 1'b0;
    ch_mask = 4'($urandom);  // must not disturb the conversion in flight
    repeat (24) tick();
    check_run(0, acc, (m != 4'd0) ? 1 : 0, 0, m, tag);
    check_run(1, acc, (m != 4'd0) ? 1 : 0, 0, m, tag);
    check_val({tag, "_busy8"}, 32'(busy8), 0);
    check_val({tag, "_busy12"}, 32'(busy12), 0);
    if (m != 4'd0) begin
      check_val({tag, "_samplecnt8"}, scnt[0], scyc[0]);
      check_val({tag, "_samplecnt12"}, scnt[1], scyc[1]);
      check_val({tag, "_ntrials"}, vals8.size(), 8);
      r = 0;
      k = 0;
      for (int i = 7; i >= 0; i--) begin
        t = r | (1 << i);
        got = (k < vals8.size()) ? vals8[k] : -1;
        check_val($sformatf("%s_trial%0d", tag, k), got, t);
        if (exp_code(0, 2'(last_ch[0])) >= t) r = t;
        k++;
      end
    end
  endtask

  task automatic do_cont(input logic [3:0] m, input int dur, input string tag);
    int acc;
    int c_stop;
    clear();
    ch_mask = m;
    enable = 1'b1;
    mode = 1'b1;
    acc = cyc + 1;
    repeat (dur) tick();
    enable = 1'b0;
    mode = 1'b0;
    c_stop = cyc;
    repeat (20) tick();
    check_val({tag, "_busy8"}, 32'(busy8), 0);
    check_val({tag, "_busy12"}, 32'(busy12), 0);
    enable = 1'b1;
    check_run(0, acc, (c_stop - acc) / lat[0], 1, m, tag);
    check_run(1, acc, (c_stop - acc) / lat[1], 1, m, tag);
  endtask

  // Drop enable while the 8-bit instance is deciding bit 3.
  task automatic do_abort(input logic [3:0] m, input string tag);
    int acc;
    clear();
    ch_mask = m;
    enable = 1'b1;
    start = 1'b1;
    acc = cyc + 1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    enable = 1'b0;
    tick();
    check_val({tag, "_busy8"}, 32'(busy8), 0);
    check_val({tag, "_busy12"}, 32'(busy12), 0);
    check_val({tag, "_sample8"}, 32'(smp8), 0);
    check_val({tag, "_value8"}, 32'(val8), 0);
    repeat (5) tick();
    enable = 1'b1;
    check_run(0, acc, 0, 1, m, tag);
    check_run(1, acc, 0, 1, m, tag);
  endtask

  task automatic do_reset_mid();
    clear();
    ch_mask = 4'b1111;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("t5_insample", 32'(smp8), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("t5async");
    ptr = '{3, 3};
    last_data = '{0, 0};
    last_ch = '{0, 0};
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    clear();
    ch_mask = 4'b0000;
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    check_val("t5_nomask_busy8", 32'(busy8), 0);
    check_val("t5_nomask_busy12", 32'(busy12), 0);
    check_val("t5_nomask_events", evq.size(), 0);
    do_single(4'b1111, "t5after");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      code8[i] = 8'd0;
      code12[i] = 12'd0;
    end
    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    code8[0] = 8'h5A;
    code12[0] = 12'hABC;
    do_single(4'b0001, "t1");

    code8[0] = 8'h00;
    do_single(4'b0001, "t2lo");
    code8[0] = 8'hFF;
    code12[0] = 12'hFFF;
    do_single(4'b0001, "t2hi");

    code8[1] = 8'h11;
    code8[3] = 8'h33;
    code12[1] = 12'h111;
    code12[3] = 12'h333;
    do_cont(4'b1010, 45, "t3");

    do_abort(4'b1010, "t4");
    do_single(4'b1010, "t4resume");

    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++) begin
        code8[i] = 8'($urandom);
        code12[i] = 12'($urandom);
      end
      do_single(4'($urandom), $sformatf("rnd%0d", it));
    end
    do_cont(4'($urandom_range(1, 15)), 30 + int'($urandom_range(0, 30)), "rndc");

    do_reset_mid();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
